// File: rtl/round_robin_pop_pkg.sv
// rtl/round_robin_pop_pkg.sv - shared constants, FSM states and helpers for round_robin_pop
//
// Contents:
//   N_FIFO       number of upstream FIFOs served by the arbiter
//   DW_DEFAULT   default data width
//   rr_state_t   one-hot FSM state encoding
//   idx_to_onehot  2-bit FIFO index to 4-bit one-hot mask
package round_robin_pop_pkg;

    localparam int N_FIFO     = 4;
    localparam int DW_DEFAULT = 6;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_ACTIVE = 4'b0010,
        ST_PAUSE  = 4'b0100,
        ST_ERROR  = 4'b1000
    } rr_state_t;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// rtl/rr_next_sel.sv - combinational round-robin search for the next eligible FIFO
//
// Ports:
//   eligible   in  4  bit i set when FIFO i may be popped this cycle
//   grant_idx  in  2  last granted index; search starts at grant_idx+1
//   found      out 1  some FIFO is eligible
//   idx        out 2  selected FIFO index (valid when found=1)
module rr_next_sel
    import round_robin_pop_pkg::*;
(
    input  logic [3:0] eligible,
    input  logic [1:0] grant_idx,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = 2'd0;
        cand  = 2'd0;
        // Walk farthest-first (offset 4 = grant_idx itself) so the nearest
        // eligible candidate after grant_idx is written last and wins.
        for (int k = 4; k >= 1; k--) begin
            cand = grant_idx + 2'(k);
            if (eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/round_robin_pop.sv
// rtl/round_robin_pop.sv - round-robin popper merging four upstream FIFOs into one downstream FIFO
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   fifo_empty[3:0]             upstream empty flags (one cycle stale)
//   fifo_error[3:0]             upstream error flags
//   valid_in[3:0]               upstream read-data valid, one cycle after pop
//   data_in0..data_in3          upstream read data
//   down_almost_full            downstream back-pressure
//   pop[3:0]                    one-hot-or-zero pop request
//   push_out, data_out          downstream write strobe and data
//   error_out                   high while in ERROR
//   grant_idx                   index of the last granted FIFO
module round_robin_pop
    import round_robin_pop_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter int N_FIFO = round_robin_pop_pkg::N_FIFO
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_FIFO-1:0] fifo_empty,
    input  logic [N_FIFO-1:0] fifo_error,
    input  logic [N_FIFO-1:0] valid_in,
    input  logic [DW-1:0]     data_in0,
    input  logic [DW-1:0]     data_in1,
    input  logic [DW-1:0]     data_in2,
    input  logic [DW-1:0]     data_in3,
    input  logic              down_almost_full,
    output logic [N_FIFO-1:0] pop,
    output logic              push_out,
    output logic [DW-1:0]     data_out,
    output logic              error_out,
    output logic [1:0]        grant_idx
);

    rr_state_t         state, state_nxt;
    logic [1:0]        grant_q;
    logic [N_FIFO-1:0] last_pop_q;
    logic              pend_valid_q;
    logic [1:0]        pend_idx_q;
    logic              push_q;
    logic [DW-1:0]     data_q;

    logic              sel_found;
    logic [1:0]        sel_idx;
    logic [N_FIFO-1:0] eligible;
    logic [N_FIFO-1:0] pend_onehot;
    logic              valid_match;
    logic              violation;
    logic              err_event;
    logic              push_nxt;
    logic [DW-1:0]     pend_data;

    // A FIFO popped last cycle is skipped: its empty flag has not caught up yet.
    assign eligible = ~fifo_empty & ~last_pop_q;

    rr_next_sel u_next_sel (
        .eligible  (eligible),
        .grant_idx (grant_q),
        .found     (sel_found),
        .idx       (sel_idx)
    );

    assign pend_onehot = idx_to_onehot(pend_idx_q);
    // Exact equality with the pending one-hot also rejects multi-bit valid_in.
    assign valid_match = pend_valid_q && (valid_in == pend_onehot);
    // Stray valid_in in the first cycle out of reset belongs to a discarded pop.
    assign violation   = (state != ST_RESET) && (valid_in != '0) && !valid_match;
    assign err_event   = (|fifo_error) || violation;
    assign push_nxt    = valid_match && (state_nxt != ST_ERROR);

    always_comb begin
        pop = '0;
        if (state == ST_ACTIVE && sel_found) begin
            pop = idx_to_onehot(sel_idx);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (err_event)             state_nxt = ST_ERROR;
                else if (down_almost_full) state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (err_event)              state_nxt = ST_ERROR;
                else if (!down_almost_full) state_nxt = ST_ACTIVE;
            end
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_ERROR;
        endcase
    end

    always_comb begin
        pend_data = data_in0;
        case (pend_idx_q)
            2'd0: pend_data = data_in0;
            2'd1: pend_data = data_in1;
            2'd2: pend_data = data_in2;
            2'd3: pend_data = data_in3;
            default: pend_data = data_in0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RESET;
            grant_q      <= 2'd3;
            last_pop_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= 2'd0;
            push_q       <= 1'b0;
            data_q       <= '0;
        end else begin
            state        <= state_nxt;
            last_pop_q   <= pop;
            pend_valid_q <= |pop;
            if (|pop) begin
                pend_idx_q <= sel_idx;
                grant_q    <= sel_idx;
            end
            push_q <= push_nxt;
            if (push_nxt) begin
                data_q <= pend_data;
            end
        end
    end

    assign push_out  = push_q;
    assign data_out  = data_q;
    assign error_out = (state == ST_ERROR);
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_round_robin_pop.sv
// tb/tb_round_robin_pop.sv - self-checking bench for round_robin_pop
module tb_round_robin_pop;

    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    fifo_empty, fifo_error, valid_in;
    logic [DW-1:0] data_in0, data_in1, data_in2, data_in3;
    logic          down_almost_full;
    logic [3:0]    pop;
    logic          push_out;
    logic [DW-1:0] data_out;
    logic          error_out;
    logic [1:0]    grant_idx;

    always #5 clk = ~clk;

    round_robin_pop #(.DW(DW), .N_FIFO(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .fifo_empty       (fifo_empty),
        .fifo_error       (fifo_error),
        .valid_in         (valid_in),
        .data_in0         (data_in0),
        .data_in1         (data_in1),
        .data_in2         (data_in2),
        .data_in3         (data_in3),
        .down_almost_full (down_almost_full),
        .pop              (pop),
        .push_out         (push_out),
        .data_out         (data_out),
        .error_out        (error_out),
        .grant_idx        (grant_idx)
    );

    // Upstream FIFO models: registered read data and a one-cycle-stale empty flag.
    logic [DW-1:0] mem [4][1024];
    int            wr_ptr [4];
    int            rd_ptr [4];
    logic [3:0]    empty_r, vld_r;
    logic [DW-1:0] dat_r [4];
    logic          flush;
    logic          inj_en;
    logic [3:0]    inj_val;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (flush) begin
                rd_ptr[i]  <= wr_ptr[i];
                empty_r[i] <= 1'b1;
                vld_r[i]   <= 1'b0;
            end else begin
                empty_r[i] <= (wr_ptr[i] == rd_ptr[i]);
                if (pop[i] === 1'b1 && wr_ptr[i] != rd_ptr[i]) begin
                    vld_r[i]  <= 1'b1;
                    dat_r[i]  <= mem[i][rd_ptr[i] % 1024];
                    rd_ptr[i] <= rd_ptr[i] + 1;
                end else begin
                    vld_r[i] <= 1'b0;
                end
            end
        end
    end

    assign fifo_empty = empty_r;
    assign valid_in   = inj_en ? inj_val : vld_r;
    assign data_in0   = dat_r[0];
    assign data_in1   = dat_r[1];
    assign data_in2   = dat_r[2];
    assign data_in3   = dat_r[3];

    // Reference model: 0=reset 1=active 2=pause 3=error, indices as ints (-1 = none).
    int            m_state, m_grant, m_last, m_pend;
    logic [DW-1:0] m_pend_data, m_data;
    bit            m_push;
    int            m_rd [4];
    bit            chk_en;
    int            want_pop;
    int            n_tests, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_pick();
        int j;
        if (m_state != 1) return -1;
        for (int k = 1; k <= 4; k++) begin
            j = (m_grant + k) % 4;
            if (fifo_empty[j] == 1'b0 && j != m_last) return j;
        end
        return -1;
    endfunction

    task automatic tick();
        int         j, ns;
        bit         err;
        logic [3:0] pmask;
        @(negedge clk);
        j = ref_pick();
        if (chk_en) begin
            chk("pop", {28'd0, pop}, (j < 0) ? 32'd0 : (32'd1 << j));
            chk("push_out", {31'd0, push_out}, {31'd0, m_push});
            if (m_push) chk("data_out", {26'd0, data_out}, {26'd0, m_data});
            chk("error_out", {31'd0, error_out}, (m_state == 3) ? 32'd1 : 32'd0);
            chk("grant_idx", {30'd0, grant_idx}, m_grant);
            if (m_state == 0) chk("rst_data_out", {26'd0, data_out}, 32'd0);
            if (want_pop >= 0) chk("dir_pop", {28'd0, pop}, want_pop);
        end
        want_pop = -1;
        pmask = (m_pend >= 0) ? (4'b0001 << m_pend) : 4'b0000;
        err = (fifo_error != 4'd0) ||
              (m_state != 0 && valid_in != 4'd0 && valid_in != pmask);
        case (m_state)
            0:       ns = 1;
            1:       ns = err ? 3 : (down_almost_full ? 2 : 1);
            2:       ns = err ? 3 : (down_almost_full ? 2 : 1);
            default: ns = 3;
        endcase
        if (reset) begin
            if (j >= 0) m_rd[j]++;
            m_state = 0; m_grant = 3; m_last = -1; m_pend = -1; m_push = 0;
        end else begin
            m_push  = (ns != 3) && (pmask != 4'd0) && (valid_in == pmask);
            m_data  = m_pend_data;
            m_state = ns;
            m_last  = j;
            m_pend  = j;
            if (j >= 0) begin
                m_grant     = j;
                m_pend_data = mem[j][m_rd[j] % 1024];
                m_rd[j]++;
            end
        end
        if (flush) for (int i = 0; i < 4; i++) m_rd[i] = wr_ptr[i];
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            mem[i][wr_ptr[i] % 1024] = DW'($urandom);
            wr_ptr[i]++;
        end
    endtask

    // Reset with FIFO flush; fill is called between flush and release.
    task automatic reset_flush();
        reset = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; chk_en = 0; want_pop = -1;
        reset = 1'b1; flush = 1'b1; inj_en = 1'b0; inj_val = 4'd0;
        fifo_error = 4'd0; down_almost_full = 1'b0;
        for (int i = 0; i < 4; i++) begin wr_ptr[i] = 0; m_rd[i] = 0; end
        m_state = 0; m_grant = 3; m_last = -1; m_pend = -1; m_push = 0;
        m_pend_data = '0; m_data = '0;

        // Reset state, then all four FIFOs non-empty: rotation 0,1,2,3,0.
        tick();
        flush = 1'b0; chk_en = 1;
        for (int i = 0; i < 4; i++) load(i, 12);
        tick();
        reset = 1'b0;
        tick();
        want_pop = 1; tick();
        want_pop = 2; tick();
        want_pop = 4; tick();
        want_pop = 8; tick();
        want_pop = 1; tick();
        tick(); tick();

        // Back-pressure for 5 cycles mid-stream.
        down_almost_full = 1'b1;
        repeat (5) tick();
        down_almost_full = 1'b0;
        repeat (6) tick();

        // One-cycle reset mid-stream: in-flight valid ignored, FIFO0 first after.
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        want_pop = 1; tick();
        repeat (3) tick();

        // Only FIFO2 holds 3 words: alternate-cycle pops, then idle.
        reset_flush();
        load(2, 3);
        tick();
        reset = 1'b0; tick();
        want_pop = 4; tick();
        want_pop = 0; tick();
        want_pop = 4; tick();
        want_pop = 0; tick();
        want_pop = 4; tick();
        want_pop = 0; tick();
        want_pop = 0; tick();
        repeat (2) tick();

        // valid_in from FIFO3 while FIFO0 is pending -> ERROR.
        reset_flush();
        load(0, 2);
        tick();
        reset = 1'b0; tick();
        tick();
        chk("pend_is_0", m_pend, 32'd0);
        inj_en = 1'b1; inj_val = 4'b1000;
        tick();
        inj_en = 1'b0;
        chk("viol_err", {31'd0, error_out}, 32'd1);
        repeat (2) tick();

        // fifo_error pulse mid-stream -> ERROR held until reset.
        reset_flush();
        for (int i = 0; i < 4; i++) load(i, 6);
        tick();
        reset = 1'b0; tick();
        repeat (3) tick();
        fifo_error = 4'b0010; tick();
        fifo_error = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            chk("err_hold", {31'd0, error_out}, 32'd1);
            chk("err_pop", {28'd0, pop}, 32'd0);
            chk("err_push", {31'd0, push_out}, 32'd0);
            tick();
        end
        reset = 1'b1; tick();
        chk("err_cleared", {31'd0, error_out}, 32'd0);

        // Randomized traffic with random back-pressure.
        reset_flush();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom % 4 == 0) load(i, 1);
            if ($urandom % 12 == 0) down_almost_full = ~down_almost_full;
            tick();
        end
        down_almost_full = 1'b0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
